copy_scheduler: RTL and testbench

COPY_SCHEDULER -- requirements
Module: copy_scheduler

---
 rtl/copy_scheduler.sv | 164 ++++++++++++++++
 tb/tb_copy_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_scheduler.sv
`timescale 1ns / 1ps
// copy_scheduler: queues copy descriptors written by a CPU and replays each one
// to a wordcopy control slave as dst/src/num/start writes followed by a stalling
// read that returns once the copy is done.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   slave_*              CPU-side Avalon-MM slave (never stalls)
//                        wr 1/2/3 = staging dst/src/num, wr 0 = push, wr 4 = clear
//                        rd 0 = status, rd 1-3 = staging, rd 4 = done count
//   wc_*                 Avalon-MM master towards the wordcopy control slave
module copy_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        wc_waitrequest,
  output logic [3:0]  wc_address,
  output logic        wc_read,
  input  logic [31:0] wc_readdata,
  output logic        wc_write,
  output logic [31:0] wc_writedata
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle, StWrDst, StWrSrc, StWrNum, StWrStart, StWaitDone, StPop
  } state_e;

  state_e state_q, state_d;

  logic [31:0]     stg_dst_q, stg_src_q, stg_num_q;
  logic [31:0]     done_cnt_q;
  logic            overflow_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic [31:0] fifo_dst [DEPTH];
  logic [31:0] fifo_src [DEPTH];
  logic [31:0] fifo_num [DEPTH];

  logic [31:0] head_dst, head_src, head_num;
  logic        push, pop, full, push_ok, clr, busy;

  // The completion read's data carries no information.
  logic unused_wc_readdata;
  assign unused_wc_readdata = ^wc_readdata;

  assign slave_waitrequest = 1'b0;

  assign head_dst = fifo_dst[rd_ptr_q];
  assign head_src = fifo_src[rd_ptr_q];
  assign head_num = fifo_num[rd_ptr_q];

  assign push    = slave_write && (slave_address == 4'd0);
  assign clr     = slave_write && (slave_address == 4'd4);
  assign pop     = (state_q == StPop);
  assign full    = (count_q == CntW'(DEPTH));
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push && (!full || pop);
  assign busy    = (state_q != StIdle) || (count_q != '0);

  // Descriptor storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_dst[wr_ptr_q] <= stg_dst_q;
      fifo_src[wr_ptr_q] <= stg_src_q;
      fifo_num[wr_ptr_q] <= stg_num_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      stg_dst_q  <= '0;
      stg_src_q  <= '0;
      stg_num_q  <= '0;
      done_cnt_q <= '0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (slave_write && slave_address == 4'd1) stg_dst_q <= slave_writedata;
      if (slave_write && slave_address == 4'd2) stg_src_q <= slave_writedata;
      if (slave_write && slave_address == 4'd3) stg_num_q <= slave_writedata;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (clr)                        overflow_q <= 1'b0;
      else if (push && full && !pop)  overflow_q <= 1'b1;
      // Zero-length descriptors are skipped and do not count as completed.
      if (clr)                          done_cnt_q <= '0;
      else if (pop && head_num != '0)   done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wc_read      = 1'b0;
    wc_write     = 1'b0;
    wc_address   = 4'd0;
    wc_writedata = '0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = (head_num == '0) ? StPop : StWrDst;
      end
      StWrDst: begin
        wc_write     = 1'b1;
        wc_address   = 4'd1;
        wc_writedata = head_dst;
        if (!wc_waitrequest) state_d = StWrSrc;
      end
      StWrSrc: begin
        wc_write     = 1'b1;
        wc_address   = 4'd2;
        wc_writedata = head_src;
        if (!wc_waitrequest) state_d = StWrNum;
      end
      StWrNum: begin
        wc_write     = 1'b1;
        wc_address   = 4'd3;
        wc_writedata = head_num;
        if (!wc_waitrequest) state_d = StWrStart;
      end
      StWrStart: begin
        wc_write = 1'b1;
        if (!wc_waitrequest) state_d = StWaitDone;
      end
      StWaitDone: begin
        wc_read = 1'b1;
        if (!wc_waitrequest) state_d = StPop;
      end
      StPop:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      unique case (slave_address)
        // Status count field is 5 bits wide; deeper FIFOs would truncate it.
        4'd0:    slave_readdata = {23'b0, overflow_q, busy, 2'b0, 5'(count_q)};
        4'd1:    slave_readdata = stg_dst_q;
        4'd2:    slave_readdata = stg_src_q;
        4'd3:    slave_readdata = stg_num_q;
        4'd4:    slave_readdata = done_cnt_q;
        default: slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_copy_scheduler.sv
`timescale 1ns / 1ps
module tb_copy_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        wc_waitrequest = 1'b0;
  logic [3:0]  wc_address;
  logic        wc_read;
  logic [31:0] wc_readdata = 32'hcafe_f00d;
  logic        wc_write;
  logic [31:0] wc_writedata;

  always #5 clk = ~clk;

  copy_scheduler #(.DEPTH(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .slave_waitrequest (slave_waitrequest),
    .slave_address     (slave_address),
    .slave_read        (slave_read),
    .slave_readdata    (slave_readdata),
    .slave_write       (slave_write),
    .slave_writedata   (slave_writedata),
    .wc_waitrequest    (wc_waitrequest),
    .wc_address        (wc_address),
    .wc_read           (wc_read),
    .wc_readdata       (wc_readdata),
    .wc_write          (wc_write),
    .wc_writedata      (wc_writedata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entry: {read, write, address, writedata}
  logic [37:0] exp_q[$];

  int wr_stall = 0;
  int rd_stall = 0;
  bit stall_all = 1'b0;
  int stall_cnt = 0;
  int acc_cnt = 0;
  int rd_acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] acc_w(input logic [3:0] a, input logic [31:0] d);
    return {1'b0, 1'b1, a, d};
  endfunction

  function automatic logic [37:0] acc_rd();
    return {1'b1, 1'b0, 4'd0, 32'd0};
  endfunction

  // Wordcopy slave model: stalls each access for a set number of cycles, then
  // accepts it at the following rising edge and checks it against the scoreboard.
  always @(negedge clk) begin
    logic [37:0] obs;
    int need;
    if (!rst_n || !(wc_read || wc_write)) begin
      wc_waitrequest = 1'b0;
      stall_cnt = 0;
    end else if (stall_all) begin
      wc_waitrequest = 1'b1;
    end else begin
      need = wc_read ? rd_stall : wr_stall;
      if (stall_cnt < need) begin
        wc_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        wc_waitrequest = 1'b0;
        stall_cnt = 0;
        acc_cnt++;
        if (wc_read) rd_acc_cnt++;
        check("rw_excl", 64'(wc_read & wc_write), 64'd0);
        obs = {wc_read, wc_write, wc_address, wc_writedata};
        if (exp_q.size() == 0) check("sb_unexp", 64'(obs), 64'd0);
        else check("sb_access", 64'(obs), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0; slave_address = '0; slave_writedata = '0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    slave_address = a; slave_read = 1'b1;
    #1;
    d = slave_readdata;
    slave_read = 1'b0; slave_address = '0;
  endtask

  task automatic stage(input logic [31:0] dst, input logic [31:0] src, input logic [31:0] num,
                       input bit accept);
    cpu_write(4'd1, dst);
    cpu_write(4'd2, src);
    cpu_write(4'd3, num);
    if (accept && num != 0) begin
      exp_q.push_back(acc_w(4'd1, dst));
      exp_q.push_back(acc_w(4'd2, src));
      exp_q.push_back(acc_w(4'd3, num));
      exp_q.push_back(acc_w(4'd0, 32'd0));
      exp_q.push_back(acc_rd());
    end
  endtask

  task automatic push_desc(input logic [31:0] dst, input logic [31:0] src, input logic [31:0] num,
                           input bit accept);
    stage(dst, src, num, accept);
    cpu_write(4'd0, 32'hdead_beef);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      cpu_read(4'd0, s);
      n++;
    end while (s[7] && n < 2000);
    check({tag, "_idle"}, 64'(s[7]), 64'd0);
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] a, input logic [31:0] v);
    logic [31:0] d;
    cpu_read(a, d);
    check(tag, 64'(d), 64'(v));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wc", 64'({wc_read, wc_write, wc_address, wc_writedata}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    expect_reg("rst_status", 4'd0, 32'd0);
    expect_reg("rst_done", 4'd4, 32'd0);
    expect_reg("rst_stg", 4'd1, 32'd0);

    // Single copy, completion read stalled 10 cycles
    wr_stall = 0; rd_stall = 10;
    push_desc(32'd6, 32'd13, 32'd5, 1'b1);
    wait_idle("single");
    expect_reg("single_done", 4'd4, 32'd1);
    expect_reg("single_status", 4'd0, 32'd0);
    expect_reg("single_stg_kept", 4'd1, 32'd6);
    check("single_sb_left", 64'(exp_q.size()), 64'd0);

    // Queue of three, every access stalled 3 cycles
    cpu_write(4'd4, 32'd0);
    wr_stall = 3; rd_stall = 3;
    push_desc(32'h100, 32'h200, 32'd3, 1'b1);
    push_desc(32'h110, 32'h210, 32'd4, 1'b1);
    push_desc(32'h120, 32'h220, 32'd9, 1'b1);
    wait_idle("queue3");
    expect_reg("queue3_done", 4'd4, 32'd3);
    check("queue3_sb_left", 64'(exp_q.size()), 64'd0);

    // Overflow with wordcopy stalled
    cpu_write(4'd4, 32'd0);
    stall_all = 1'b1; wr_stall = 0; rd_stall = 0;
    for (int i = 0; i < 5; i++) push_desc(32'h300 + i, 32'h400 + i, 32'd1 + i, i < 4);
    expect_reg("ovf_status", 4'd0, 32'h184);
    cpu_write(4'd4, 32'd0);
    expect_reg("ovf_clr_status", 4'd0, 32'h084);
    expect_reg("ovf_clr_done", 4'd4, 32'd0);
    stall_all = 1'b0;
    wait_idle("ovf");
    expect_reg("ovf_done", 4'd4, 32'd4);
    check("ovf_sb_left", 64'(exp_q.size()), 64'd0);

    // Zero-length descriptor is skipped
    cpu_write(4'd4, 32'd0);
    push_desc(32'h500, 32'h600, 32'd0, 1'b1);
    push_desc(32'h510, 32'h610, 32'd2, 1'b1);
    wait_idle("zero");
    expect_reg("zero_done", 4'd4, 32'd1);
    check("zero_sb_left", 64'(exp_q.size()), 64'd0);

    // Full FIFO, push lands in the POP cycle
    cpu_write(4'd4, 32'd0);
    stall_all = 1'b1;
    for (int i = 0; i < 4; i++) push_desc(32'h700 + i, 32'h800 + i, 32'd2 + i, 1'b1);
    expect_reg("full_status", 4'd0, 32'h084);
    stage(32'h7ee, 32'h8ee, 32'd7, 1'b1);
    base = rd_acc_cnt;
    stall_all = 1'b0;
    n = 0;
    while (rd_acc_cnt == base && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("full_pop_seen", 64'(rd_acc_cnt != base), 64'd1);
    cpu_write(4'd0, 32'd0);
    expect_reg("full_pushpop_status", 4'd0, 32'h084);
    wait_idle("full");
    expect_reg("full_done", 4'd4, 32'd5);
    check("full_sb_left", 64'(exp_q.size()), 64'd0);

    // Reset while waiting for completion with two descriptors queued
    cpu_write(4'd4, 32'd0);
    rd_stall = 1000;
    for (int i = 0; i < 3; i++) push_desc(32'h900 + i, 32'ha00 + i, 32'd1, 1'b1);
    n = 0;
    while (!wc_read && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_mid_reading", 64'(wc_read), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wc", 64'({wc_read, wc_write, wc_address, wc_writedata}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rd_stall = 0;
    base = acc_cnt;
    expect_reg("rst_mid_status", 4'd0, 32'd0);
    expect_reg("rst_mid_stg", 4'd3, 32'd0);
    repeat (20) @(posedge clk);
    check("rst_mid_no_access", 64'(acc_cnt - base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
